// File: rtl/adcif.sv
// -----------------------------------------------------------------------------
// adcif : I2S slave receiver.
// Samples externally driven LRCK/BCK/DATA, deserializes 24-bit two's-complement
// left/right words (MSB first, one-BCK delay after each LRCK edge) and presents
// each complete stereo pair with a one-cycle sample_valid strobe.
//
// Optional build macro: ADCIF_FRAME_ERR_EN
//   defined   -> frame_err pulses with sample_valid when either word of the pair
//                was shorter than 24 bits; an 8-bit saturating error counter
//                (err_cnt_r) is kept internally for debug readout.
//   undefined -> frame_err is tied low and no short-word tracking is built.
// -----------------------------------------------------------------------------
module adcif #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i2s_lrck,
    input  logic        i2s_bck,
    input  logic        i2s_data,
    output logic        sample_valid,
    output logic [23:0] left_data,
    output logic [23:0] right_data,
    output logic        frame_err
);

    // Fewer than two stages would not give metastability protection.
    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    // Word value is the shift register left-aligned so that short words keep
    // their MSB position and are zero-padded at the LSBs.
    function automatic logic [23:0] align_word(input logic [23:0] sh,
                                               input logic [4:0]  cnt);
        logic [4:0] amt;
        amt = 5'd24 - cnt;
        return sh << amt;
    endfunction

    logic [SS-1:0] lrck_sync_r;
    logic [SS-1:0] bck_sync_r;
    logic [SS-1:0] data_sync_r;
    logic          lrck_d_r;
    logic          bck_d_r;

    logic          lrck_s;
    logic          bck_s;
    logic          data_s;
    logic          lrck_edge_s;
    logic          lrck_rise_s;
    logic          bck_rise_s;

    logic [23:0]   shift_r;
    logic [4:0]    bit_cnt_r;
    logic          skip_r;
    logic          armed_r;
    logic [23:0]   left_hold_r;

    logic          sample_valid_r;
    logic [23:0]   left_data_r;
    logic [23:0]   right_data_r;

    logic [23:0]   commit_word_s;
    logic          word_short_s;

    // Synchronize all three I2S pins through identical chains so DATA stays
    // aligned with BCK.
    always_ff @(posedge clk) begin
        if (rst) begin
            lrck_sync_r <= '0;
            bck_sync_r  <= '0;
            data_sync_r <= '0;
        end else begin
            lrck_sync_r <= {lrck_sync_r[SS-2:0], i2s_lrck};
            bck_sync_r  <= {bck_sync_r[SS-2:0],  i2s_bck};
            data_sync_r <= {data_sync_r[SS-2:0], i2s_data};
        end
    end

    assign lrck_s = lrck_sync_r[SS-1];
    assign bck_s  = bck_sync_r[SS-1];
    assign data_s = data_sync_r[SS-1];

    // One delay flop behind the synchronizers for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            lrck_d_r <= 1'b0;
            bck_d_r  <= 1'b0;
        end else begin
            lrck_d_r <= lrck_s;
            bck_d_r  <= bck_s;
        end
    end

    assign lrck_edge_s   = lrck_s ^ lrck_d_r;
    assign lrck_rise_s   = lrck_s & ~lrck_d_r;
    assign bck_rise_s    = bck_s & ~bck_d_r;
    assign commit_word_s = align_word(shift_r, bit_cnt_r);
    assign word_short_s  = (bit_cnt_r < 5'd24);

    // Deserializer: restart on every LRCK edge, drop the delay-slot bit, then
    // shift in up to 24 bits MSB first and ignore any further slot bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r   <= 24'd0;
            bit_cnt_r <= 5'd0;
            skip_r    <= 1'b1;
        end else if (lrck_edge_s) begin
            shift_r   <= 24'd0;
            bit_cnt_r <= 5'd0;
            // A BCK rise in the same cycle is the delay slot itself.
            skip_r    <= ~bck_rise_s;
        end else if (bck_rise_s) begin
            if (skip_r) begin
                skip_r <= 1'b0;
            end else if (bit_cnt_r < 5'd24) begin
                shift_r   <= {shift_r[22:0], data_s};
                bit_cnt_r <= bit_cnt_r + 5'd1;
            end else begin
                shift_r   <= shift_r;
                bit_cnt_r <= bit_cnt_r;
            end
        end else begin
            shift_r   <= shift_r;
            bit_cnt_r <= bit_cnt_r;
            skip_r    <= skip_r;
        end
    end

    // Word commit: a rising LRCK edge closes the left word into the holding
    // register; a falling edge closes the right word and, once armed, updates
    // both outputs and strobes sample_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            left_hold_r    <= 24'd0;
            armed_r        <= 1'b0;
            sample_valid_r <= 1'b0;
            left_data_r    <= 24'd0;
            right_data_r   <= 24'd0;
        end else begin
            sample_valid_r <= 1'b0;
            if (lrck_edge_s) begin
                if (lrck_rise_s) begin
                    left_hold_r <= commit_word_s;
                end else begin
                    if (armed_r) begin
                        left_data_r    <= left_hold_r;
                        right_data_r   <= commit_word_s;
                        sample_valid_r <= 1'b1;
                    end
                    // The first falling edge after reset only arms, so no
                    // partial pair is ever presented.
                    armed_r <= 1'b1;
                end
            end
        end
    end

    assign sample_valid = sample_valid_r;
    assign left_data    = left_data_r;
    assign right_data   = right_data_r;

`ifdef ADCIF_FRAME_ERR_EN
    logic       left_short_r;
    logic       frame_err_r;
    logic [7:0] err_cnt_r;

    // Short-word tracking: remember whether the left word was short and flag
    // the pair when either word had fewer than 24 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            left_short_r <= 1'b0;
            frame_err_r  <= 1'b0;
            err_cnt_r    <= 8'd0;
        end else begin
            frame_err_r <= 1'b0;
            if (lrck_edge_s) begin
                if (lrck_rise_s) begin
                    left_short_r <= word_short_s;
                end else if (armed_r && (left_short_r || word_short_s)) begin
                    frame_err_r <= 1'b1;
                    if (err_cnt_r != 8'hFF) begin
                        err_cnt_r <= err_cnt_r + 8'd1;
                    end
                end
            end
        end
    end

    assign frame_err = frame_err_r;
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_adcif.sv
// -----------------------------------------------------------------------------
// tb_adcif : scoreboard bench for the I2S slave receiver. Stimulus tasks drive
// I2S frames and push the expected stereo pair whenever the reference model
// sees a right word close; an independent monitor pops on every sample_valid.
// -----------------------------------------------------------------------------
module tb_adcif;

    localparam int H = 4; // clk cycles per BCK half period (f_bck = f_clk/8)

`ifdef ADCIF_FRAME_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i2s_lrck = 1'b0;
    logic        i2s_bck = 1'b0;
    logic        i2s_data = 1'b0;
    logic        sample_valid;
    logic [23:0] left_data;
    logic [23:0] right_data;
    logic        frame_err;

    always #5 clk = ~clk;

    adcif #(.SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .i2s_lrck     (i2s_lrck),
        .i2s_bck      (i2s_bck),
        .i2s_data     (i2s_data),
        .sample_valid (sample_valid),
        .left_data    (left_data),
        .right_data   (right_data),
        .frame_err    (frame_err)
    );

    typedef struct packed {
        logic [23:0] l;
        logic [23:0] r;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    logic        pin_lrck = 1'b0;
    logic        m_armed = 1'b0;
    logic [23:0] m_left = 24'd0;
    logic        m_lshort = 1'b0;
    logic [23:0] cur_word = 24'd0;
    logic        cur_short = 1'b0;

    // monitor state
    exp_t        mon_e;
    logic [23:0] hold_l = 24'd0;
    logic [23:0] hold_r = 24'd0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic bit_at(input logic [23:0] w, input int wl,
                                    input logic fill, input int i);
        if (i < wl) return w[wl-1-i];
        return fill;
    endfunction

    // One channel slot: delay-slot BCK, then n data bits (word bits MSB first,
    // then fill bits). Optional LRCK/BCK-rise alignment and mid-word reset.
    task automatic send_channel(input logic ch, input logic [23:0] w,
                                input int wl, input int n, input logic fill,
                                input logic aligned, input int rst_at);
        logic [23:0] ew;
        if (ch != pin_lrck) begin
            if (ch == 1'b1) begin
                m_left   = cur_word;
                m_lshort = cur_short;
            end else begin
                if (m_armed)
                    sb.push_back('{l: m_left, r: cur_word,
                                   err: ERR_EN & (m_lshort | cur_short)});
                m_armed = 1'b1;
            end
        end
        pin_lrck = ch;
        ew = 24'd0;
        for (int i = 0; i < 24; i++)
            if (i < n) ew[23-i] = bit_at(w, wl, fill, i);
        cur_word  = ew;
        cur_short = (n < 24);

        if (aligned) begin
            i2s_bck = 1'b0;
            repeat (H) tick();
            i2s_lrck = ch;
            i2s_bck  = 1'b1;
            repeat (H) tick();
        end else begin
            i2s_bck  = 1'b0;
            i2s_lrck = ch;
            repeat (H) tick();
            i2s_bck = 1'b1;
            repeat (H) tick();
        end
        for (int i = 0; i < n; i++) begin
            i2s_bck  = 1'b0;
            i2s_data = bit_at(w, wl, fill, i);
            if (i == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                m_armed = 1'b0;
                repeat (H-1) tick();
            end else begin
                repeat (H) tick();
            end
            i2s_bck = 1'b1;
            repeat (H) tick();
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r,
                              input int wl, input int n, input logic fill,
                              input logic aligned);
        send_channel(1'b0, l, wl, n, fill, aligned, -1);
        send_channel(1'b1, r, wl, n, fill, aligned, -1);
    endtask

    // Monitor: pop and compare on each strobe, otherwise outputs must hold.
    always @(negedge clk) begin
        if (rst) begin
            hold_l = 24'd0;
            hold_r = 24'd0;
        end else if (sample_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got L=%h R=%h E=%b, required no strobe",
                         left_data, right_data, frame_err);
            end else begin
                mon_e = sb.pop_front();
                if (left_data !== mon_e.l || right_data !== mon_e.r ||
                    frame_err !== mon_e.err) begin
                    errors++;
                    $display("FAIL pair: got L=%h R=%h E=%b, required L=%h R=%h E=%b",
                             left_data, right_data, frame_err,
                             mon_e.l, mon_e.r, mon_e.err);
                end
                hold_l = mon_e.l;
                hold_r = mon_e.r;
            end
        end else begin
            checks++;
            if (left_data !== hold_l || right_data !== hold_r || frame_err !== 1'b0) begin
                errors++;
                $display("FAIL hold: got L=%h R=%h E=%b, required L=%h R=%h E=0",
                         left_data, right_data, frame_err, hold_l, hold_r);
            end
        end
    end

    int          nsel[5] = '{24, 31, 20, 63, 23};
    logic [23:0] rl;
    logic [23:0] rr;

    initial begin
        rst = 1'b1;
        repeat (5) tick();
        rst = 1'b0;
        tick();

        // basic 64-BCK frames: first frame arms, pairs follow
        repeat (3) send_frame(24'h123456, 24'hABCDEF, 24, 31, 1'b0, 1'b0);
        // sign extremes
        repeat (2) send_frame(24'h800000, 24'h7FFFFF, 24, 31, 1'b0, 1'b0);
        // 16-bit words: zero-padded at LSBs, short-word flag
        repeat (2) send_frame(24'h00BEEF, 24'h001234, 16, 16, 1'b0, 1'b0);
        // 128-BCK slots with trailing ones
        send_frame(24'h000001, 24'hABCDEF, 24, 127, 1'b1, 1'b0);
        // LRCK edge coincident with the delay-slot BCK rise
        repeat (2) send_frame(24'hC0FFEE, 24'h5A5A5A, 24, 31, 1'b0, 1'b1);
        // randomized frames
        for (int f = 0; f < 20; f++) begin
            rl = 24'($urandom);
            rr = 24'($urandom);
            send_frame(rl, rr, 24, nsel[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
        end
        // reset after 10 bits of a left word, then re-arm and resume
        send_channel(1'b0, 24'h3C3C3C, 24, 31, 1'b0, 1'b0, 10);
        send_channel(1'b1, 24'h111111, 24, 31, 1'b0, 1'b0, -1);
        send_frame(24'h2468AC, 24'hFEDCBA, 24, 31, 1'b0, 1'b0);
        send_frame(24'h000000, 24'hFFFFFF, 24, 31, 1'b1, 1'b0);
        // closing falling edge commits the last pair
        send_channel(1'b0, 24'h000000, 24, 4, 1'b0, 1'b0, -1);

        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pairs outstanding, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
